// File: rtl/mask_pkg.sv
// Shared definitions for the masked AES randomness path:
// LFSR constants, producer state encoding, mask generator sizing.
package mask_pkg;

  localparam int LFSR_W = 64;
  localparam logic [LFSR_W-1:0] TAP_MASK = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_t;

  function automatic int num_needed(input int shares);
    int n;
    case (shares)
      2: n = 1;
      3: n = 2;
      4: n = 4;
      5: n = 5;
      default: n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational unroll of STEPS Galois shifts of the 64-bit LFSR
// (x^64+x^63+x^61+x^60+1, right-shifting form).
module lfsr_step
  import mask_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next
);

  // Apply the shift-and-conditional-xor STEPS times in one cycle
  always_comb begin
    logic [LFSR_W-1:0] s;
    s = state;
    for (int i = 0; i < STEPS; i++) begin
      s = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAP_MASK : '0);
    end
    next = s;
  end

endmodule

// File: rtl/prng_feed.sv
// Seeded LFSR word producer feeding the share-zero mask generators;
// discards a warm-up prefix after every seed load.
module prng_feed
  import mask_pkg::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 2,
  parameter int NUM_WORDS     = num_needed(NUM_SHARES),
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                                in_clock,
  input  logic                                in_reset,
  input  logic [LFSR_W-1:0]                   in_seed,
  input  logic                                in_seed_valid,
  output logic                                out_seed_ready,
  output logic [NUM_WORDS-1:0][BIT_WIDTH-1:0] out_random,
  output logic                                out_valid,
  input  logic                                in_ready
);

  localparam int NB = NUM_WORDS * BIT_WIDTH;

  if (NUM_SHARES < 2 || NUM_SHARES > 5) begin : g_bad_shares
    $error("prng_feed: NUM_SHARES must be 2..5");
  end
  if (NB > LFSR_W) begin : g_bad_width
    $error("prng_feed: NUM_WORDS*BIT_WIDTH exceeds 64");
  end
  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warm
    $error("prng_feed: WARMUP_CYCLES must be 1..255");
  end

  state_t            state;
  state_t            state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [7:0]        cnt;
  logic              seed_acc;

  lfsr_step #(
    .STEPS(NB)
  ) u_step (
    .state(lfsr),
    .next (lfsr_adv)
  );

  assign seed_acc   = in_seed_valid && out_seed_ready;
  assign out_random = lfsr[NB-1:0];

  // State register
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: seed accept wins over any transfer in RUN
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (seed_acc) state_nxt = WARMUP;
      WARMUP:  if (cnt == 8'd1) state_nxt = RUN;
      RUN:     if (seed_acc) state_nxt = WARMUP;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the registered state only
  always_comb begin
    out_seed_ready = 1'b0;
    out_valid      = 1'b0;
    unique case (state)
      IDLE:    out_seed_ready = 1'b1;
      WARMUP:  out_seed_ready = 1'b0;
      RUN: begin
        out_seed_ready = 1'b1;
        out_valid      = 1'b1;
      end
      default: out_seed_ready = 1'b0;
    endcase
  end

  // LFSR and warm-up counter; zero seed remapped to avoid the stuck state
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      lfsr <= '0;
      cnt  <= '0;
    end else if (seed_acc) begin
      lfsr <= (in_seed == '0) ? 64'h1 : in_seed;
      cnt  <= 8'(WARMUP_CYCLES);
    end else if (state == WARMUP) begin
      lfsr <= lfsr_adv;
      cnt  <= cnt - 8'd1;
    end else if (state == RUN && in_ready) begin
      lfsr <= lfsr_adv;
    end
  end

endmodule

// File: tb/tb_prng_feed.sv
// Directed + randomized bench for prng_feed against an arithmetic
// reference of the Galois LFSR sequence.
module tb_prng_feed;

  logic clk = 1'b0;
  logic rst;

  logic [63:0]      seed_a;
  logic             sv_a;
  logic             sr_a;
  logic [0:0][1:0]  rnd_a;
  logic             val_a;
  logic             rdy_a;

  logic [63:0]      seed_b;
  logic             sv_b;
  logic             sr_b;
  logic [4:0][7:0]  rnd_b;
  logic             val_b;
  logic             rdy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prng_feed #(
    .NUM_SHARES(2), .BIT_WIDTH(2), .WARMUP_CYCLES(4)
  ) dut_a (
    .in_clock(clk), .in_reset(rst), .in_seed(seed_a),
    .in_seed_valid(sv_a), .out_seed_ready(sr_a),
    .out_random(rnd_a), .out_valid(val_a), .in_ready(rdy_a)
  );

  prng_feed #(
    .NUM_SHARES(5), .BIT_WIDTH(8), .WARMUP_CYCLES(3)
  ) dut_b (
    .in_clock(clk), .in_reset(rst), .in_seed(seed_b),
    .in_seed_valid(sv_b), .out_seed_ready(sr_b),
    .out_random(rnd_b), .out_valid(val_b), .in_ready(rdy_b)
  );

  // Reference: n single Galois steps written from the polynomial
  function automatic logic [63:0] adv(input logic [63:0] x, input int n);
    logic [63:0] s;
    s = x;
    for (int i = 0; i < n; i++) begin
      if (s[0]) s = (s >> 1) ^ 64'hD800_0000_0000_0000;
      else      s = s >> 1;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] ea;
  logic [63:0] eb;

  initial begin
    rst = 1'b1;
    seed_a = '0; sv_a = 1'b0; rdy_a = 1'b0;
    seed_b = '0; sv_b = 1'b0; rdy_b = 1'b0;
    #1;
    chk("rst_valid", 64'(val_a), 64'd0);
    chk("rst_sready", 64'(sr_a), 64'd1);
    chk("rst_random", 64'(rnd_a), 64'd0);
    chk("rst_valid_b", 64'(val_b), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_valid", 64'(val_a), 64'd0);
    end

    // Seed and warm-up on the small configuration
    seed_a = 64'h0123_4567_89AB_CDEF;
    sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) begin
        chk("warm_valid", 64'(val_a), 64'd0);
        chk("warm_sready", 64'(sr_a), 64'd0);
      end
      tick();
    end
    ea = 64'h0123_4567_89AB_CDEF;
    repeat (4) ea = adv(ea, 2);
    chk("first_valid", 64'(val_a), 64'd1);
    chk("first_word", 64'(rnd_a), 64'(ea[1:0]));

    // Streaming at full rate
    rdy_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("stream", 64'(rnd_a), 64'(ea[1:0]));
      tick();
      ea = adv(ea, 2);
    end
    rdy_a = 1'b0;

    // Zero seed behaves as seed 1
    seed_a = '0;
    sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    repeat (4) tick();
    ea = adv(64'h1, 8);
    rdy_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("zero_seed", 64'({val_a, rnd_a}), 64'({1'b1, ea[1:0]}));
      tick();
      ea = adv(ea, 2);
    end
    chk("zero_seed_alive", 64'(ea != '0), 64'd1);

    // Reseed colliding with a transfer
    seed_a = 64'hFFFF;
    sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    rdy_a = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("coll_valid", 64'(val_a), 64'd0);
      tick();
    end
    tick();
    ea = adv(64'hFFFF, 8);
    chk("coll_restart", 64'({val_a, rnd_a}), 64'({1'b1, ea[1:0]}));
    rdy_a = 1'b1;
    tick();
    ea = adv(ea, 2);
    chk("coll_next", 64'(rnd_a), 64'(ea[1:0]));
    rdy_a = 1'b0;

    // Seed held through warm-up is taken only on the first RUN cycle
    seed_a = 64'hA5A5_0000_1234_5678;
    sv_a = 1'b1;
    tick();
    seed_a = 64'h0F0F_F0F0_3C3C_C3C3;
    for (int i = 1; i < 4; i++) begin
      chk("blk_sready", 64'(sr_a), 64'd0);
      tick();
    end
    tick();
    ea = adv(64'hA5A5_0000_1234_5678, 8);
    chk("blk_run", 64'({val_a, sr_a, rnd_a}), 64'({2'b11, ea[1:0]}));
    tick();
    sv_a = 1'b0;
    chk("blk_rewarm", 64'(val_a), 64'd0);
    repeat (4) tick();
    ea = adv(64'h0F0F_F0F0_3C3C_C3C3, 8);
    chk("blk_second", 64'({val_a, rnd_a}), 64'({1'b1, ea[1:0]}));

    // Backpressure on the wide configuration
    seed_b = 64'hDEAD_BEEF_CAFE_F00D;
    sv_b = 1'b1;
    tick();
    sv_b = 1'b0;
    repeat (3) tick();
    eb = adv(64'hDEAD_BEEF_CAFE_F00D, 120);
    for (int i = 0; i < 200; i++) begin
      chk("bp_word", 64'({val_b, rnd_b}), 64'({1'b1, eb[39:0]}));
      rdy_b = 1'($urandom_range(1));
      tick();
      if (rdy_b) eb = adv(eb, 40);
    end
    rdy_b = 1'b0;

    // Asynchronous reset in RUN clears outputs within the cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(val_a), 64'd0);
    chk("arst_random", 64'(rnd_a), 64'd0);
    chk("arst_sready", 64'(sr_a), 64'd1);
    chk("arst_b", 64'({val_b, rnd_b}), 64'd0);
    tick();
    rst = 1'b0;
    rdy_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_idle", 64'(val_a), 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
